// File: rtl/fifo_wr_arb_if.sv
// Write-side bundle between the requesters/FIFO and the fifo_wr_arb arbiter.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface fifo_wr_arb_if #(
  parameter int N_REQ      = 4,
  parameter int FIFO_WIDTH = 8
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*FIFO_WIDTH-1:0] din_bus;
  logic                        full;
  logic [N_REQ-1:0]            gnt;
  logic                        wr_en;
  logic [FIFO_WIDTH-1:0]       din;
  logic [2:0]                  owner;
  logic                        busy;

  modport master (
    output req, din_bus, full,
    input  gnt, wr_en, din, owner, busy
  );

  modport slave (
    input  req, din_bus, full,
    output gnt, wr_en, din, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding N_REQ requesters into one FIFO write port.
// Optional per-requester word counters are built when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arb #(
  parameter int N_REQ      = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_wr_arb_if.slave          wr,
  output logic [N_REQ*16-1:0]   stat_cnt
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          owner_q, owner_d;
  logic [2:0]          last_owner_q, last_owner_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic                found_hi, found_any;
  logic [2:0]          win_hi, win_any, winner;
  logic                owner_req;
  logic                accept;
  logic [N_REQ-1:0]    gnt_c;
  logic [FIFO_WIDTH-1:0] din_c;

  // Round-robin: lowest requester above last_owner, else wrap to lowest overall.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    win_hi    = '0;
    win_any   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (wr.req[i]) begin
        if (!found_hi && (3'(i) > last_owner_q)) begin
          found_hi = 1'b1;
          win_hi   = 3'(i);
        end
        if (!found_any) begin
          found_any = 1'b1;
          win_any   = 3'(i);
        end
      end
    end
    winner = found_hi ? win_hi : win_any;
  end

  always_comb begin
    owner_req = 1'b0;
    din_c     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        owner_req = wr.req[i];
        din_c     = wr.din_bus[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_d       = beat_q;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|wr.req) begin
          owner_d      = winner;
          last_owner_d = winner;
          beat_d       = '0;
          state_d      = BURST;
        end
      end
      BURST: begin
        if (!owner_req) begin
          state_d = IDLE;
        end else if (!wr.full) begin
          accept = 1'b1;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      gnt_c[i] = accept && (owner_q == 3'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= 3'(N_REQ - 1);
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_q       <= beat_d;
    end
  end

  assign wr.wr_en = accept;
  assign wr.gnt   = gnt_c;
  assign wr.din   = din_c;
  assign wr.owner = owner_q;
  assign wr.busy  = (state_q == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_c[i] && (stat_q[i] != 16'hFFFF)) begin
        stat_d[i] = stat_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = stat_q;
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of write requesters (2..8).
REQ-002 SHALL have parameter FIFO_WIDTH, default 8, meaning the data word width in bits, matching the FIFO write port.
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning the maximum words accepted per grant (1..16).
REQ-004 SHALL have port clk  input  1  the single clock (the FIFO write clock); all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  N_REQ  per-requester request; the word is held on the requester's din_bus slice while high.
REQ-007 SHALL have port din_bus  input  N_REQ*FIFO_WIDTH  requester data; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 SHALL have port full  input  1  FIFO full flag, synchronous to clk.
REQ-009 SHALL have port gnt  output  N_REQ  one-hot per-word acknowledge; requester i's word is consumed in any cycle gnt[i]=1.
REQ-010 SHALL have port wr_en  output  1  FIFO write enable.
REQ-011 SHALL have port din  output  FIFO_WIDTH  FIFO write data.
REQ-012 SHALL have port owner  output  3  index of the current burst owner, valid while busy=1.
REQ-013 SHALL have port busy  output  1  high while the FSM is in BURST.
REQ-014 SHALL have port stat_cnt  output  N_REQ*16  per-requester accepted-word counters (see Configuration).

Function
REQ-015 SHALL implement a two-state FSM: IDLE and BURST.
REQ-016 IDLE: when req is nonzero, SHALL select the winner by round-robin, searching from (last_owner+1) mod N_REQ upward, register owner=winner, last_owner=winner, beat=0, and go to BURST on the next edge.
REQ-017 IDLE: SHALL hold wr_en=0 and gnt=0; arbitration costs exactly one bubble cycle per burst.
REQ-018 BURST: accept = req[owner] & ~full, computed combinationally; wr_en=accept, gnt=accept ? onehot(owner) : 0, din=din_bus slice of owner (regardless of accept).
REQ-019 BURST: on each accept SHALL increment beat; after the accept at beat==BURST_LEN-1 SHALL return to IDLE.
REQ-020 BURST: if req[owner]=0 (with or without full), SHALL return to IDLE on that edge without writing (early release).
REQ-021 BURST with full=1 and req[owner]=1 SHALL stall: hold owner and beat, wr_en=0, indefinitely until full clears.
REQ-022 Requests from non-owners during BURST SHALL be ignored until the next IDLE arbitration; no word is ever dropped or duplicated.
REQ-023 SHALL never assert wr_en while full=1, and gnt SHALL never have more than one bit set.
REQ-024 beat SHALL be ceil(log2(BURST_LEN+1)) bits wide and never wrap within a burst.

Reset
REQ-025 On rst=1, asynchronously: state=IDLE, beat=0, owner=0, last_owner=N_REQ-1 (requester 0 wins first), busy=0; wr_en=0, gnt=0 follow combinationally; stat_cnt=0.
REQ-026 Reset asserted mid-burst SHALL abort the burst immediately; the partially transferred burst is not resumed.

Configuration
REQ-027 Macro FIFO_WR_ARB_STATS_EN: when defined, stat_cnt slice i SHALL increment by 1 on each cycle gnt[i]=1, saturating at 16'hFFFF; when undefined, stat_cnt SHALL be tied to 0 and no counter registers exist.

Verification
REQ-028 Single requester: req=4'b0001 steady, full=0, BURST_LEN=4 -> 1 idle cycle, 4 consecutive wr_en cycles with din=slice 0, 1 idle, repeat.
REQ-029 Fairness: req=4'b1111 steady after reset -> owner sequence 0,1,2,3,0 with exactly 4 writes each; gnt one-hot throughout.
REQ-030 Backpressure: owner 2 at beat 1, full=1 for 5 cycles -> wr_en=0 and gnt=0 for 5 cycles, owner stays 2, writes resume at beat 1, total 4 words.
REQ-031 Early release: owner 1 drops req after 2 accepts -> FSM to IDLE, next owner 2 (if requesting), requester 1 sees exactly 2 gnt pulses.
REQ-032 Reset mid-burst: rst pulsed at beat 2 of owner 3 -> wr_en=0, busy=0 same cycle; after release with req=4'b1000, first grant goes to requester 3 via last_owner=N_REQ-1 wrap.
REQ-033 With FIFO_WR_ARB_STATS_EN: after REQ-029 running 2 rounds, each stat_cnt slice=8; without macro stat_cnt=0.
